systolic_feeder: RTL and testbench

//  Upstream sequencer for the N x N weight-stationary PE array.
//  - Buffers one N x N weight tile, then shifts it into the array with exactly N consecutive ctrl cycles.
//  - Streams feature vectors into array rows with a 2-cycle-per-row skew, matching the PE's two-register partial-sum path.
//  - Tags valid results at the bottom of the array.

---
 rtl/systolic_feeder.sv | 104 ++++++++++
 tb/tb_systolic_feeder.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_feeder.sv
// systolic_feeder: weight-tile loader and skewed feature streamer for an N x N weight-stationary PE array.
// Optional stall counter output enabled by defining FEEDER_STALL_CNT_EN.
module systolic_feeder #(
    parameter int W  = 8,
    parameter int N  = 4,
    parameter int CW = 16
) (
    input  logic           clk_in,
    input  logic           nrst_in,
    input  logic           start_in,
    input  logic [CW-1:0]  num_vec_in,
    input  logic           wgt_valid_in,
    output logic           wgt_ready_out,
    input  logic [N*W-1:0] wgt_row_in,
    input  logic           feat_valid_in,
    output logic           feat_ready_out,
    input  logic [N*W-1:0] feat_vec_in,
    output logic           ctrl_out,
    output logic [N*W-1:0] col_top_out,
    output logic [N*W-1:0] row_feat_out,
    output logic           res_valid_out,
    output logic           busy_out,
    output logic           done_out
`ifdef FEEDER_STALL_CNT_EN
    ,
    output logic [CW-1:0]  stall_cnt_out
`endif
);
    localparam int KW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [2:0] {IDLE, FILL, LOAD, PRIME, STREAM, DRAIN} state_t;

    state_t         state, state_nxt;
    logic [KW-1:0]  cnt;
    logic [CW-1:0]  rem;
    logic [N*W-1:0] wbuf [N];
    logic [2*N-1:0] vpipe;
    logic           w_acc, f_acc, cnt_last;

    assign wgt_ready_out  = state == FILL;
    assign feat_ready_out = state == STREAM && rem != '0;
    assign w_acc          = wgt_valid_in && wgt_ready_out;
    assign f_acc          = feat_valid_in && feat_ready_out;
    assign cnt_last       = cnt == KW'(N - 1);
    assign ctrl_out       = state == LOAD;
    // Buffer entry k leaves first-in-first-out, so accepted row k settles in array row N-1-k.
    assign col_top_out    = (state == LOAD) ? wbuf[cnt] : '0;
    assign res_valid_out  = vpipe[2*N-1];
    assign busy_out       = state != IDLE;
    assign done_out       = state == DRAIN && vpipe == '0;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_in) state_nxt = FILL;
            FILL:    if (w_acc && cnt_last) state_nxt = LOAD;
            LOAD:    if (cnt_last) state_nxt = PRIME;
            PRIME:   state_nxt = STREAM;
            STREAM:  if (rem == '0) state_nxt = DRAIN;
            DRAIN:   if (vpipe == '0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge nrst_in) begin
        if (!nrst_in) begin
            state <= IDLE;
            cnt   <= '0;
            rem   <= '0;
            vpipe <= '0;
            for (int i = 0; i < N; i++) wbuf[i] <= '0;
        end else begin
            state <= state_nxt;
            if (w_acc || state == LOAD) cnt <= cnt_last ? '0 : cnt + 1'b1;
            if (w_acc) wbuf[cnt] <= wgt_row_in;
            if (state == IDLE && start_in) rem <= num_vec_in;
            else if (f_acc) rem <= rem - 1'b1;
            vpipe <= {vpipe[2*N-2:0], f_acc};
        end
    end

    // Row r waits 2r+1 cycles so it meets the partial sum travelling two registers per row.
    for (genvar r = 0; r < N; r++) begin : g_row
        logic [W-1:0] dl [2*r+1];
        always_ff @(posedge clk_in or negedge nrst_in) begin
            if (!nrst_in) begin
                for (int i = 0; i <= 2*r; i++) dl[i] <= '0;
            end else begin
                dl[0] <= f_acc ? feat_vec_in[r*W +: W] : '0;
                for (int i = 1; i <= 2*r; i++) dl[i] <= dl[i-1];
            end
        end
        assign row_feat_out[r*W +: W] = dl[2*r];
    end

`ifdef FEEDER_STALL_CNT_EN
    always_ff @(posedge clk_in or negedge nrst_in) begin
        if (!nrst_in) stall_cnt_out <= '0;
        else if (state == IDLE && start_in) stall_cnt_out <= '0;
        else if (state == STREAM && rem != '0 && !feat_valid_in && stall_cnt_out != '1)
            stall_cnt_out <= stall_cnt_out + 1'b1;
    end
`endif
endmodule

// File: tb/tb_systolic_feeder.sv
// tb_systolic_feeder: drives the feeder into a behavioural PE array and checks every cycle
// against a job-level model of acceptance history, skew, latency and matrix products.
module tb_systolic_feeder;
    localparam int W = 8, N = 4, CW = 16;

    logic clk = 0, nrst = 0, start = 0, wgt_valid = 0, feat_valid = 0;
    logic [CW-1:0]  num_vec = '0;
    logic [N*W-1:0] wgt_row = '0, feat_vec = '0;
    logic wgt_ready, feat_ready, ctrl, res_valid, busy, done;
    logic [N*W-1:0] col_top, row_feat;
`ifdef FEEDER_STALL_CNT_EN
    logic [CW-1:0] stall_cnt;
`endif

    systolic_feeder #(.W(W), .N(N), .CW(CW)) dut (
        .clk_in(clk), .nrst_in(nrst), .start_in(start), .num_vec_in(num_vec),
        .wgt_valid_in(wgt_valid), .wgt_ready_out(wgt_ready), .wgt_row_in(wgt_row),
        .feat_valid_in(feat_valid), .feat_ready_out(feat_ready), .feat_vec_in(feat_vec),
        .ctrl_out(ctrl), .col_top_out(col_top), .row_feat_out(row_feat),
        .res_valid_out(res_valid), .busy_out(busy), .done_out(done)
`ifdef FEEDER_STALL_CNT_EN
        , .stall_cnt_out(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0, checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Behavioural PE array: weights shift down one row per ctrl cycle; partial sums take two registers per row.
    logic [W-1:0] pw [N][N], pin [N][N], pout [N][N];
    always @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int r = 0; r < N; r++)
                for (int c = 0; c < N; c++) begin
                    pw[r][c] <= '0; pin[r][c] <= '0; pout[r][c] <= '0;
                end
        end else begin
            for (int r = 0; r < N; r++)
                for (int c = 0; c < N; c++) begin
                    int q;
                    q = (r > 0) ? r - 1 : 0;
                    if (ctrl) pw[r][c] <= (r == 0) ? col_top[c*W +: W] : pw[q][c];
                    pin[r][c] <= ctrl ? '0 : ((r == 0) ? col_top[c*W +: W] : pout[q][c]);
                    if (!ctrl) pout[r][c] <= W'(pin[r][c] + pw[r][c] * row_feat[r*W +: W]);
                end
        end
    end

    logic [N*W-1:0] bottom;
    always_comb begin
        bottom = '0;
        for (int c = 0; c < N; c++) bottom[c*W +: W] = pout[N-1][c];
    end

    // Job-level model state
    int cyc = 0;
    logic           hv   [64];
    logic [N*W-1:0] hvec [64];
    logic [N*W-1:0] wacc [N];
    int  wk = 0, job_nv = 0, res_cnt = 0, acc_cnt = 0, ctrl_run = 0, ctrl_runs = 0;
    int  done_cnt = 0, last_acc_cyc = 0;
    bit  job_active = 0, prev_res = 0;
    logic [N*W-1:0] res_log [$];
    int             res_cyc_log [$];

    always @(negedge clk) begin
        int j, s;
        logic [N*W-1:0] exp_cols;
        logic [W-1:0] exp_row;
        if (!nrst) begin
            chk("rst_col_top", col_top, 0);
            chk("rst_row_feat", row_feat, 0);
            chk("rst_flags", {ctrl, res_valid, busy, done, wgt_ready, feat_ready}, 0);
`ifdef FEEDER_STALL_CNT_EN
            chk("rst_stall_cnt", stall_cnt, 0);
`endif
            for (int i = 0; i < 64; i++) hv[i] = 0;
            job_active = 0; wk = 0; ctrl_run = 0; prev_res = 0;
        end else begin
            cyc++;
            for (int r = 0; r < N; r++) begin
                j = (cyc - 1 - 2*r) & 63;
                exp_row = hv[j] ? hvec[j][r*W +: W] : '0;
                chk($sformatf("row_feat[%0d]", r), row_feat[r*W +: W], exp_row);
            end
            j = (cyc - 2*N) & 63;
            chk("res_valid", res_valid, hv[j]);
            if (res_valid) begin
                for (int c = 0; c < N; c++) begin
                    s = 0;
                    for (int r = 0; r < N; r++)
                        s += int'(wacc[N-1-r][c*W +: W]) * int'(hvec[j][r*W +: W]);
                    exp_cols[c*W +: W] = W'(s);
                end
                chk("columns", bottom, exp_cols);
                res_cnt++;
                res_log.push_back(bottom);
                res_cyc_log.push_back(cyc);
            end
            chk("busy", busy, job_active);
            if (!job_active) chk("done_idle", done, 0);
            else if (job_nv > 0) chk("done", done, !res_valid && prev_res && res_cnt == job_nv);
            if (ctrl) ctrl_run++;
            else if (ctrl_run > 0) begin
                chk("ctrl_run_len", ctrl_run, N);
                ctrl_run = 0;
                ctrl_runs++;
            end
            j = cyc & 63;
            hv[j] = feat_valid && feat_ready;
            hvec[j] = feat_vec;
            if (hv[j]) begin acc_cnt++; last_acc_cyc = cyc; end
            if (wgt_valid && wgt_ready) begin wacc[wk] = wgt_row; wk = (wk + 1) % N; end
            if (job_active && done) begin
                chk("job_accepts", acc_cnt, job_nv);
                chk("job_results", res_cnt, job_nv);
                job_active = 0;
                done_cnt++;
            end else if (!job_active && start) begin
                job_active = 1; job_nv = int'(num_vec); res_cnt = 0; acc_cnt = 0; wk = 0;
            end
            prev_res = res_valid;
        end
    end

    // Job description shared by the driver tasks
    logic [N*W-1:0] jrows [N];
    logic [N*W-1:0] jvecs [$];
    int             jgaps [$];
    bit             jrnd = 0;

    task automatic start_job(input int nv);
        @(posedge clk); #1 start = 1; num_vec = CW'(nv);
        @(posedge clk); #1 start = 0; num_vec = CW'($urandom);
    endtask

    task automatic load_weights();
        int k = 0, n = 0;
        while (k < N && n < 200) begin
            @(posedge clk); #1
            wgt_valid = jrnd ? 1'($urandom) : 1'b1;
            wgt_row = wgt_valid ? jrows[k] : $urandom;
            @(negedge clk);
            if (wgt_valid && wgt_ready) k++;
            n++;
        end
        chk("wgt_accepts", k, N);
    endtask

    task automatic feed();
        int i = 0, n = 0, g, nv;
        nv = jvecs.size();
        g = (nv > 0) ? jgaps[0] : 0;
        while (i < nv && n < 1000) begin
            @(posedge clk); #1
            wgt_valid = 0;
            start = jrnd && ($urandom_range(7) == 0);
            num_vec = CW'($urandom_range(9));
            if (g > 0) begin feat_valid = 0; feat_vec = $urandom; g--; end
            else begin feat_valid = 1; feat_vec = jvecs[i]; end
            @(negedge clk);
            if (feat_valid && feat_ready) begin
                i++;
                if (i < nv) g = jgaps[i];
            end
            n++;
        end
        @(posedge clk); #1 feat_valid = 0; start = 0; wgt_valid = 0;
        chk("feat_accepts", i, nv);
    endtask

    task automatic run_job();
        int d0, n = 0;
        d0 = done_cnt;
        start_job(jvecs.size());
        load_weights();
        feed();
        while (done_cnt == d0 && n < 400) begin @(posedge clk); n++; end
        chk("done_seen", done_cnt - d0, 1);
    endtask

    function automatic void identity_rows();
        for (int k = 0; k < N; k++) jrows[k] = (N*W)'(1) << (k*W);
    endfunction

    initial begin
        int l0, c0, d0, a, n;
        repeat (3) @(negedge clk);
        #2 nrst = 1;

        // 1: all-ones weights, one vector [1,2,3,4]
        for (int k = 0; k < N; k++) jrows[k] = 32'h01010101;
        jvecs = {32'h04030201}; jgaps = {0}; jrnd = 0;
        l0 = res_log.size(); c0 = ctrl_runs;
        run_job();
        chk("t1_nres", res_log.size() - l0, 1);
        chk("t1_ctrl_runs", ctrl_runs - c0, 1);
        if (res_log.size() > l0) begin
            chk("t1_cols", res_log[l0], 32'h0a0a0a0a);
            chk("t1_latency", res_cyc_log[l0] - last_acc_cyc, 2*N);
        end

        // 2: identity rows, reversed placement, back-to-back vectors
        identity_rows();
        jvecs = {32'h08070605, 32'h02000001}; jgaps = {0, 0};
        l0 = res_log.size();
        run_job();
        chk("t2_nres", res_log.size() - l0, 2);
        if (res_log.size() > l0 + 1) begin
            chk("t2_cols0", res_log[l0], 32'h05060708);
            chk("t2_cols1", res_log[l0+1], 32'h01000002);
            chk("t2_adjacent", res_cyc_log[l0+1] - res_cyc_log[l0], 1);
        end

        // 3: three idle cycles between vectors
        jvecs = {$urandom, $urandom}; jgaps = {0, 3};
        l0 = res_log.size();
        run_job();
        chk("t3_nres", res_log.size() - l0, 2);
        if (res_log.size() > l0 + 1) chk("t3_gap", res_cyc_log[l0+1] - res_cyc_log[l0], 4);
`ifdef FEEDER_STALL_CNT_EN
        chk("t3_stall_cnt", stall_cnt, 3);
`endif

        // 4: empty job
        for (int k = 0; k < N; k++) jrows[k] = $urandom;
        jvecs = {}; jgaps = {};
        l0 = res_log.size(); c0 = ctrl_runs;
        run_job();
        chk("t4_nres", res_log.size() - l0, 0);
        chk("t4_ctrl_runs", ctrl_runs - c0, 1);

        // 5: wrap-around, repeated job
        for (int k = 0; k < N; k++) jrows[k] = 32'h10101010;
        jvecs = {32'h10101010}; jgaps = {0};
        for (int rep = 0; rep < 2; rep++) begin
            l0 = res_log.size();
            run_job();
            chk("t5_nres", res_log.size() - l0, 1);
            if (res_log.size() > l0) chk("t5_cols", res_log[l0], 0);
        end

        // 6: reset mid-stream, then a fresh job
        identity_rows();
        d0 = done_cnt;
        start_job(5);
        load_weights();
        a = 0; n = 0;
        while (a < 2 && n < 100) begin
            @(posedge clk); #1 wgt_valid = 0; feat_valid = 1; feat_vec = $urandom;
            @(negedge clk);
            if (feat_ready) a++;
            n++;
        end
        chk("t6_accepts", a, 2);
        @(posedge clk); #2 nrst = 0; feat_valid = 0;
        @(negedge clk);
        chk("t6_busy", busy, 0);
        repeat (2) @(negedge clk);
        #2 nrst = 1;
        repeat (20) @(posedge clk);
        chk("t6_no_done", done_cnt - d0, 0);
        jvecs = {32'h04030201, 32'h01010101}; jgaps = {0, 1};
        l0 = res_log.size();
        run_job();
        chk("t6_nres", res_log.size() - l0, 2);
        if (res_log.size() > l0) chk("t6_cols0", res_log[l0], 32'h01020304);

        // Randomized jobs with random weights, gaps, valid drops and ignored starts
        jrnd = 1;
        repeat (25) begin
            int nv;
            for (int k = 0; k < N; k++) jrows[k] = $urandom;
            nv = $urandom_range(6);
            jvecs = {}; jgaps = {};
            for (int i = 0; i < nv; i++) begin
                jvecs.push_back($urandom);
                jgaps.push_back($urandom_range(3));
            end
            l0 = res_log.size();
            run_job();
            chk("rand_nres", res_log.size() - l0, nv);
        end

        repeat (5) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
